qmeas_frontend_seq: RTL

//  Measurement-side responder for the secant current-reference search: takes i_ref, drives the front-end DAC,

---
 rtl/qmeas_pkg.sv | 28 ++
 rtl/qmeas_avg_acc.sv | 48 ++++
 rtl/qmeas_frontend_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/qmeas_pkg.sv
// +--------------------------------------------------------------------------+
// | qmeas_pkg : shared state encodings and default widths for qmeas blocks   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package qmeas_pkg;

    localparam int DEF_BUS_WIDTH     = 10;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_AVG_LOG2      = 2;
    localparam int DEF_TIMEOUT       = 255;

    localparam int                     ACC_W    = DEF_BUS_WIDTH + DEF_AVG_LOG2;
    localparam logic [DEF_BUS_WIDTH-1:0] ALL_ONES = '1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_CONV   = 3'd3;
    localparam state_t ST_WAIT   = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/qmeas_avg_acc.sv
// +--------------------------------------------------------------------------+
// | qmeas_avg_acc : ADC sample accumulator with sample count and last flag   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module qmeas_avg_acc
    import qmeas_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int AVG_LOG2  = DEF_AVG_LOG2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          accumulate,
    input  logic [BUS_WIDTH-1:0]          sample,
    output logic [BUS_WIDTH+AVG_LOG2-1:0] sum,
    output logic                          last
);

    localparam int                SUM_W    = BUS_WIDTH + AVG_LOG2;
    localparam int                CNT_W    = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] count;

    // sum is the running total including the sample currently offered
    assign sum  = acc + SUM_W'(sample);
    assign last = (count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (accumulate) begin
            acc   <= sum;
            count <= count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/qmeas_frontend_seq.sv
// +--------------------------------------------------------------------------+
// | qmeas_frontend_seq : DAC load, settle, averaged ADC measurement sequencer|
// | Optional macro QMEAS_TIMEOUT_EN adds a per-conversion timeout. Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module qmeas_frontend_seq
    import qmeas_pkg::*;
#(
    parameter int BUS_WIDTH     = DEF_BUS_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int AVG_LOG2      = DEF_AVG_LOG2,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    output logic [BUS_WIDTH-1:0] dac_data,
    output logic                 dac_load,
    output logic                 adc_start,
    input  logic                 adc_done,
    input  logic [BUS_WIDTH-1:0] adc_data,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 timeout
);

    localparam int SUM_W   = BUS_WIDTH + AVG_LOG2;
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES : TIMEOUT;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum;
    logic             last;
    logic             acc_clear;
    logic             acc_take;
    logic             conv_abort;

    assign acc_clear = (state == ST_IDLE) && enable;
    assign acc_take  = (state == ST_WAIT) && adc_done;

`ifdef QMEAS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    assign conv_abort = (state == ST_WAIT) && !adc_done && (cnt == TO_LAST);
`else
    assign conv_abort = 1'b0;
`endif

    qmeas_avg_acc #(
        .BUS_WIDTH (BUS_WIDTH),
        .AVG_LOG2  (AVG_LOG2)
    ) u_avg_acc (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear),
        .accumulate (acc_take),
        .sample     (adc_data),
        .sum        (sum),
        .last       (last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (enable) state_next = ST_LOAD;
            ST_LOAD:   state_next = (SETTLE_CYCLES == 0) ? ST_CONV : ST_SETTLE;
            ST_SETTLE: if (cnt == CNT_W'(1)) state_next = ST_CONV;
            ST_CONV:   state_next = ST_WAIT;
            ST_WAIT: begin
                if (adc_done) begin
                    state_next = last ? ST_DONE : ST_CONV;
                end else if (conv_abort) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dac_load  = 1'b0;
        adc_start = 1'b0;
        ready     = 1'b0;
        case (state)
            ST_LOAD: dac_load  = 1'b1;
            ST_CONV: adc_start = 1'b1;
            ST_DONE: ready     = 1'b1;
            default: ;
        endcase
    end

    // cnt serves as the settle down-counter and, with timeout, the WAIT up-counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            dac_data   <= '0;
            q_measured <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE:   if (enable) dac_data <= i_ref;
                ST_LOAD:   cnt <= CNT_W'(SETTLE_CYCLES);
                ST_SETTLE: cnt <= cnt - CNT_W'(1);
                ST_CONV:   cnt <= '0;
                ST_WAIT: begin
                    if (adc_done && last) begin
                        q_measured <= sum[SUM_W-1:AVG_LOG2];
                    end else if (conv_abort) begin
                        q_measured <= {BUS_WIDTH{1'b1}};
                    end
`ifdef QMEAS_TIMEOUT_EN
                    if (!adc_done) cnt <= cnt + CNT_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef QMEAS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout <= 1'b0;
        end else if (conv_abort) begin
            timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

`default_nettype wire
